// File: rtl/mac_sequencer.sv
// mac_sequencer
//   Sequences one dot-product job on the shared MAC datapath. A start command
//   carries the vector length. Operand pairs are taken from an upstream
//   valid/ready stream and forwarded to the operand registers, with
//   clear_mult_out marking the first pair of the job. After the last pair the
//   sequencer waits PIPE_LAT cycles for the accumulator to settle, captures
//   acc_in into result_out and pulses result_valid.
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   start, len                  job request; sampled only while idle
//   in_valid, in_ready          upstream operand handshake
//   a_in, b_in                  upstream operands
//   acc_in                      accumulator value returned by the MAC
//   data_a_out, data_b_out      operands to the MAC operand registers
//   clear_mult_out, valid_out   first-pair marker and pair valid to the MAC
//   busy                        job in progress
//   result_out, result_valid    captured result and its one-cycle strobe
//   error                       sticky stall-timeout flag
//
// Build option
//   MAC_SEQ_TIMEOUT_EN  enables the stall counter. A job that sees TIMEOUT
//                       consecutive LOAD cycles without in_valid is abandoned
//                       and error is set. Without it, error is tied to 0 and
//                       LOAD waits indefinitely.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; zero-length jobs complete from here
// LOAD  | accepting operand pairs, rem pairs still to go
// DRAIN | last pair issued; waiting PIPE_LAT cycles for the accumulator

module mac_sequencer #(
    parameter int LEN_W    = 8,
    parameter int ACC_W    = 20,
    parameter int PIPE_LAT = 2,
    parameter int TIMEOUT  = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a_in,
    input  logic [7:0]       b_in,
    input  logic [ACC_W-1:0] acc_in,
    output logic [7:0]       data_a_out,
    output logic [7:0]       data_b_out,
    output logic             clear_mult_out,
    output logic             valid_out,
    output logic             busy,
    output logic [ACC_W-1:0] result_out,
    output logic             result_valid,
    output logic             error
);

    // dcnt is 4 bits wide and the stall counter 8 bits wide.
    if (PIPE_LAT < 1 || PIPE_LAT > 15 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
        $error("mac_sequencer: PIPE_LAT must be 1..15 and TIMEOUT 1..255");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             first_q, first_d;
    logic [3:0]       dcnt_q, dcnt_d;
    logic [7:0]       data_a_q, data_a_d;
    logic [7:0]       data_b_q, data_b_d;
    logic             clear_q, clear_d;
    logic             valid_q, valid_d;
    logic [ACC_W-1:0] result_q, result_d;
    logic             result_valid_q, result_valid_d;

    logic xfer;
    logic start_job;
    logic start_zero;
    logic last_xfer;
    logic stall_timeout;

    assign xfer       = in_valid && (state_q == LOAD);
    assign start_job  = (state_q == IDLE) && start && (len != '0);
    assign start_zero = (state_q == IDLE) && start && (len == '0);
    // LOAD leaves on rem==1, so rem never wraps below zero.
    assign last_xfer  = xfer && (rem_q == LEN_W'(1));

`ifdef MAC_SEQ_TIMEOUT_EN
    logic [7:0] stall_q, stall_d;
    logic       error_q, error_d;

    assign stall_timeout = (state_q == LOAD) && !in_valid && (stall_q == 8'(TIMEOUT - 1));

    always_comb begin
        stall_d = stall_q;
        error_d = error_q;
        if (start_job || start_zero) begin
            stall_d = '0;
            error_d = 1'b0;
        end else if (state_q == LOAD) begin
            if (in_valid) begin
                stall_d = '0;
            end else if (stall_timeout) begin
                stall_d = '0;
                error_d = 1'b1;
            end else begin
                stall_d = stall_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            error_q <= 1'b0;
        end else begin
            stall_q <= stall_d;
            error_q <= error_d;
        end
    end

    assign error = error_q;
`else
    assign stall_timeout = 1'b0;
    assign error         = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_job) state_d = LOAD;
            end
            LOAD: begin
                if (last_xfer)          state_d = DRAIN;
                else if (stall_timeout) state_d = IDLE;
            end
            DRAIN: begin
                if (dcnt_q == 4'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        rem_d          = rem_q;
        first_d        = first_q;
        dcnt_d         = dcnt_q;
        data_a_d       = data_a_q;
        data_b_d       = data_b_q;
        clear_d        = 1'b0;
        valid_d        = 1'b0;
        result_d       = result_q;
        result_valid_d = 1'b0;

        if (start_job) begin
            rem_d   = len;
            first_d = 1'b1;
        end
        if (start_zero) begin
            result_d       = '0;
            result_valid_d = 1'b1;
        end
        if (xfer) begin
            data_a_d = a_in;
            data_b_d = b_in;
            valid_d  = 1'b1;
            clear_d  = first_q;
            first_d  = 1'b0;
            rem_d    = rem_q - LEN_W'(1);
        end
        if (last_xfer) begin
            dcnt_d = 4'(PIPE_LAT);
        end
        if (state_q == DRAIN) begin
            dcnt_d = dcnt_q - 4'd1;
            // acc_in holds the final sum once PIPE_LAT edges have passed
            if (dcnt_q == 4'd1) begin
                result_d       = acc_in;
                result_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q          <= '0;
            first_q        <= 1'b0;
            dcnt_q         <= '0;
            data_a_q       <= '0;
            data_b_q       <= '0;
            clear_q        <= 1'b0;
            valid_q        <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            rem_q          <= rem_d;
            first_q        <= first_d;
            dcnt_q         <= dcnt_d;
            data_a_q       <= data_a_d;
            data_b_q       <= data_b_d;
            clear_q        <= clear_d;
            valid_q        <= valid_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign in_ready       = (state_q == LOAD);
    assign busy           = (state_q != IDLE);
    assign data_a_out     = data_a_q;
    assign data_b_out     = data_b_q;
    assign clear_mult_out = clear_q;
    assign valid_out      = valid_q;
    assign result_out     = result_q;
    assign result_valid   = result_valid_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer
//   Self-checking bench for mac_sequencer. A small accumulator model stands in
//   for the MAC (one register stage behind valid_out, so acc_in is settled
//   when the sequencer captures it with PIPE_LAT=2). Expected pairs and
//   results are queued when stimulus is driven and compared by a monitor when
//   the DUT produces them.
`timescale 1ns/1ps

module tb_mac_sequencer;

    localparam int LEN_W      = 8;
    localparam int ACC_W      = 20;
    localparam int PIPE_LAT   = 2;
    localparam int TB_TIMEOUT = 10;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       a_in = '0;
    logic [7:0]       b_in = '0;
    logic [ACC_W-1:0] acc_in;
    logic [7:0]       data_a_out;
    logic [7:0]       data_b_out;
    logic             clear_mult_out;
    logic             valid_out;
    logic             busy;
    logic [ACC_W-1:0] result_out;
    logic             result_valid;
    logic             error;

    int errors = 0;
    int checks = 0;

    mac_sequencer #(
        .LEN_W   (LEN_W),
        .ACC_W   (ACC_W),
        .PIPE_LAT(PIPE_LAT),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .len           (len),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .a_in          (a_in),
        .b_in          (b_in),
        .acc_in        (acc_in),
        .data_a_out    (data_a_out),
        .data_b_out    (data_b_out),
        .clear_mult_out(clear_mult_out),
        .valid_out     (valid_out),
        .busy          (busy),
        .result_out    (result_out),
        .result_valid  (result_valid),
        .error         (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [ACC_W-1:0] acc_model;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc_model <= '0;
        else if (valid_out)
            acc_model <= (clear_mult_out ? '0 : acc_model)
                         + ACC_W'(data_a_out) * ACC_W'(data_b_out);
    end
    assign acc_in = acc_model;

    typedef struct {
        logic [ACC_W-1:0] val;
        bit               chk_lat;
    } res_t;

    res_t        exp_res_q[$];
    logic [16:0] exp_pair_q[$];
    bit          job_first = 1'b0;
    logic [7:0]  last_a = '0;
    logic [7:0]  last_b = '0;
    int          last_valid_cyc = 0;
    int          gap_cyc = 0;

    task automatic run_monitor();
        logic [16:0] ep;
        res_t        er;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (valid_out) begin
                    if (clear_mult_out) gap_cyc = cyc - last_valid_cyc;
                    last_valid_cyc = cyc;
                    checks++;
                    if (exp_pair_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_pair: got a=%0d b=%0d clear=%0d, required no valid_out",
                                 data_a_out, data_b_out, clear_mult_out);
                    end else begin
                        ep = exp_pair_q.pop_front();
                        if ({clear_mult_out, data_a_out, data_b_out} !== ep) begin
                            errors++;
                            $display("FAIL pair: got clear=%0d a=%0d b=%0d, required clear=%0d a=%0d b=%0d",
                                     clear_mult_out, data_a_out, data_b_out, ep[16], ep[15:8], ep[7:0]);
                        end
                        last_a = ep[15:8];
                        last_b = ep[7:0];
                    end
                end else begin
                    checks++;
                    if (data_a_out !== last_a || data_b_out !== last_b || clear_mult_out !== 1'b0) begin
                        errors++;
                        $display("FAIL hold: got a=%0d b=%0d clear=%0d, required a=%0d b=%0d clear=0",
                                 data_a_out, data_b_out, clear_mult_out, last_a, last_b);
                    end
                end
                if (result_valid) begin
                    checks++;
                    if (exp_res_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_result: got result_valid=1 result=%0d, required none",
                                 result_out);
                    end else begin
                        er = exp_res_q.pop_front();
                        if (result_out !== er.val) begin
                            errors++;
                            $display("FAIL result: got %0d, required %0d", result_out, er.val);
                        end
                        checks++;
                        if (busy !== 1'b0) begin
                            errors++;
                            $display("FAIL busy_at_result: got %0d, required 0", busy);
                        end
                        if (er.chk_lat) begin
                            checks++;
                            if (cyc - last_valid_cyc != PIPE_LAT) begin
                                errors++;
                                $display("FAIL result_latency: got %0d, required %0d",
                                         cyc - last_valid_cyc, PIPE_LAT);
                            end
                        end
                    end
                end
            end
        end
    endtask

    task automatic start_job(input logic [LEN_W-1:0] l, input logic [ACC_W-1:0] exp_val,
                             input bit expect_result);
        res_t r;
        r.val     = exp_val;
        r.chk_lat = (l != '0);
        if (expect_result) exp_res_q.push_back(r);
        job_first = 1'b1;
        start     = 1'b1;
        len       = l;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input int gap);
        int n;
        repeat (gap) begin
            a_in = 8'($urandom);
            b_in = 8'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        a_in     = a;
        b_in     = b;
        n        = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL pair_accept: got in_ready=%0d after 50 cycles, required 1", in_ready);
            in_valid = 1'b0;
        end else begin
            exp_pair_q.push_back({job_first, a, b});
            job_first = 1'b0;
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_res_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (exp_res_q.size() != 0) begin
            errors++;
            $display("FAIL result_wait: got %0d results outstanding, required 0", exp_res_q.size());
            exp_res_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({valid_out, clear_mult_out, busy, in_ready, result_valid, error} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b, required 000000",
                     {valid_out, clear_mult_out, busy, in_ready, result_valid, error});
        end
        checks++;
        if (data_a_out !== 8'd0 || data_b_out !== 8'd0 || result_out !== '0) begin
            errors++;
            $display("FAIL reset_data: got a=%0d b=%0d result=%0d, required 0 0 0",
                     data_a_out, data_b_out, result_out);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%0d in_ready=%0d, required 0 0", busy, in_ready);
        end
    endtask

    task automatic test_basic();
        start_job(8'd3, 20'd33, 1'b1);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_entry: got busy=%0d in_ready=%0d, required 1 1", busy, in_ready);
        end
        send_pair(8'd2, 8'd3, 0);
        send_pair(8'd4, 8'd5, 0);
        send_pair(8'd1, 8'd7, 0);
        wait_done();
    endtask

    task automatic test_backpressure();
        start_job(8'd2, 20'd37, 1'b1);
        send_pair(8'd6, 8'd6, 3);
        send_pair(8'd1, 8'd1, 3);
        wait_done();
    endtask

    task automatic test_zero_len();
        start_job(8'd0, 20'd0, 1'b1);
        checks++;
        if (result_valid !== 1'b1 || result_out !== '0) begin
            errors++;
            $display("FAIL zero_len_result: got valid=%0d result=%0d, required 1 0",
                     result_valid, result_out);
        end
        checks++;
        if (busy !== 1'b0 || valid_out !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_idle: got busy=%0d valid_out=%0d, required 0 0", busy, valid_out);
        end
        @(posedge clk); #1;
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_after: got valid=%0d busy=%0d, required 0 0", result_valid, busy);
        end
        wait_done();
    endtask

    task automatic test_ignored_start();
        start_job(8'd2, 20'd14, 1'b1);
        send_pair(8'd1, 8'd2, 0);
        start = 1'b1;
        len   = 8'd9;
        send_pair(8'd3, 8'd4, 1);
        start = 1'b0;
        wait_done();
        repeat (3) begin
            @(posedge clk); #1;
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL ignored_start_idle: got busy=%0d, required 0", busy);
            end
        end
    endtask

    task automatic test_reset_mid();
        start_job(8'd4, 20'd0, 1'b0);
        send_pair(8'd1, 8'd1, 0);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({valid_out, clear_mult_out, busy, in_ready, result_valid} !== 5'b0
            || data_a_out !== 8'd0 || data_b_out !== 8'd0 || result_out !== '0) begin
            errors++;
            $display("FAIL reset_mid: got flags=%b a=%0d b=%0d result=%0d, required all 0",
                     {valid_out, clear_mult_out, busy, in_ready, result_valid},
                     data_a_out, data_b_out, result_out);
        end
        exp_pair_q.delete();
        last_a = '0;
        last_b = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        start_job(8'd1, 20'd12, 1'b1);
        send_pair(8'd3, 8'd4, 0);
        wait_done();
    endtask

    task automatic test_back_to_back();
        int n;
        start_job(8'd2, 20'd61, 1'b1);
        send_pair(8'd5, 8'd5, 0);
        send_pair(8'd6, 8'd6, 0);
        n = 0;
        while (result_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (result_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_result_wait: got result_valid=%0d, required 1", result_valid);
        end
        start_job(8'd1, 20'd56, 1'b1);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_start: got busy=%0d, required 1", busy);
        end
        send_pair(8'd7, 8'd8, 0);
        wait_done();
        checks++;
        if (gap_cyc != PIPE_LAT + 2) begin
            errors++;
            $display("FAIL b2b_gap: got %0d idle cycles, required %0d", gap_cyc - 1, PIPE_LAT + 1);
        end
    endtask

`ifdef MAC_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        start_job(8'd2, 20'd0, 1'b0);
        send_pair(8'd5, 8'd5, 0);
        repeat (TB_TIMEOUT - 1) begin
            @(posedge clk); #1;
            checks++;
            if (error !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL timeout_early: got error=%0d busy=%0d, required 0 1", error, busy);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (error !== 1'b1 || busy !== 1'b0 || valid_out !== 1'b0) begin
            errors++;
            $display("FAIL timeout_hit: got error=%0d busy=%0d valid_out=%0d, required 1 0 0",
                     error, busy, valid_out);
        end
        repeat (4) begin @(posedge clk); #1; end
        checks++;
        if (error !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: got error=%0d, required 1", error);
        end
        start_job(8'd0, 20'd0, 1'b1);
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: got error=%0d, required 0", error);
        end
        wait_done();
    endtask
`endif

    initial begin
        fork
            run_monitor();
        join_none
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_len();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
`ifdef MAC_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        repeat (3) @(posedge clk);
        checks++;
        if (exp_res_q.size() != 0 || exp_pair_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: got %0d results %0d pairs pending, required 0 0",
                     exp_res_q.size(), exp_pair_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running at 200000 ns, required finished");
        $fatal(1, "watchdog expired");
    end

endmodule
